// File: rtl/cnn_pkg.sv
// Shared CNN definitions: data/address widths, pooling FSM state encoding and
// a signed-max helper reused by later layers.
package cnn_pkg;

    localparam int DATA_W      = 32;
    localparam int FEAT_ADDR_W = 12;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_R0   = 3'd1;
    localparam logic [2:0] ST_R1   = 3'd2;
    localparam logic [2:0] ST_R2   = 3'd3;
    localparam logic [2:0] ST_R3   = 3'd4;
    localparam logic [2:0] ST_LAST = 3'd5;
    localparam logic [2:0] ST_WR   = 3'd6;
    localparam logic [2:0] ST_FIN  = 3'd7;

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool_addr_gen.sv
// Pooling-window address generator: c/oy/ox output counters plus the
// 2x2 source tap and destination address arithmetic (wraps modulo 2^ADDR_W).
module maxpool_addr_gen
    import cnn_pkg::*;
#(
    parameter int IMG_W    = 12,
    parameter int IMG_H    = 12,
    parameter int CHANNELS = 6,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 1000,
    parameter int ADDR_W   = FEAT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              advance_i,
    input  logic [1:0]        tap_i,
    output logic [ADDR_W-1:0] src_addr_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic              last_o
);

    localparam int OW = IMG_W / 2;
    localparam int OH = IMG_H / 2;
    localparam int CW = 16;

    localparam logic [CW-1:0] OX_LAST = CW'(OW - 1);
    localparam logic [CW-1:0] OY_LAST = CW'(OH - 1);
    localparam logic [CW-1:0] C_LAST  = CW'(CHANNELS - 1);

    logic [CW-1:0] ox_q, ox_d;
    logic [CW-1:0] oy_q, oy_d;
    logic [CW-1:0] c_q,  c_d;

    // ox innermost, then oy, then channel
    always_comb begin
        ox_d = ox_q;
        oy_d = oy_q;
        c_d  = c_q;
        if (clear_i) begin
            ox_d = '0;
            oy_d = '0;
            c_d  = '0;
        end else if (advance_i) begin
            if (ox_q == OX_LAST) begin
                ox_d = '0;
                if (oy_q == OY_LAST) begin
                    oy_d = '0;
                    c_d  = (c_q == C_LAST) ? '0 : c_q + 1'b1;
                end else begin
                    oy_d = oy_q + 1'b1;
                end
            end else begin
                ox_d = ox_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ox_q <= '0;
            oy_q <= '0;
            c_q  <= '0;
        end else begin
            ox_q <= ox_d;
            oy_q <= oy_d;
            c_q  <= c_d;
        end
    end

    assign last_o = (ox_q == OX_LAST) && (oy_q == OY_LAST) && (c_q == C_LAST);

    // tap_i[1] selects the lower row (dy), tap_i[0] the right column (dx)
    assign src_addr_o = ADDR_W'(SRC_BASE)
                      + ADDR_W'(32'(c_q) * 32'(IMG_W * IMG_H))
                      + ADDR_W'((32'(oy_q) * 2 + 32'(tap_i[1])) * 32'(IMG_W))
                      + ADDR_W'(32'(ox_q) * 2 + 32'(tap_i[0]));

    assign dst_addr_o = ADDR_W'(DST_BASE)
                      + ADDR_W'(32'(c_q) * 32'(OW * OH))
                      + ADDR_W'(32'(oy_q) * 32'(OW))
                      + ADDR_W'(32'(ox_q));

endmodule

// File: rtl/maxpool_unit.sv
// 2x2 stride-2 max pooling over feature memory, six cycles per output.
// Define MAXPOOL_RELU_EN to clamp negative pooled values to zero on write.
module maxpool_unit
    import cnn_pkg::*;
#(
    parameter int IMG_W    = 12,
    parameter int IMG_H    = 12,
    parameter int CHANNELS = 6,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 1000,
    parameter int ADDR_W   = FEAT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] feature_idata,
    output logic [ADDR_W-1:0] feature_addr,
    output logic [DATA_W-1:0] feature_data,
    output logic              feature_mem_en,
    output logic              busy,
    output logic              done
);

    logic [2:0]               state_q, state_d;
    logic signed [DATA_W-1:0] max_q, max_d;
    logic signed [DATA_W-1:0] wr_val;
    logic signed [DATA_W-1:0] rd_val;
    logic [1:0]               tap;
    logic                     last_out;
    logic [ADDR_W-1:0]        src_addr;
    logic [ADDR_W-1:0]        dst_addr;

    assign rd_val = $signed(feature_idata);

    maxpool_addr_gen #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .CHANNELS (CHANNELS),
        .SRC_BASE (SRC_BASE),
        .DST_BASE (DST_BASE),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (state_q == ST_IDLE && start),
        .advance_i  (state_q == ST_WR),
        .tap_i      (tap),
        .src_addr_o (src_addr),
        .dst_addr_o (dst_addr),
        .last_o     (last_out)
    );

    // Read data lags the address by one cycle, so each state folds in the
    // pixel addressed by the previous state.
    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        tap     = 2'd0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_R0;
            ST_R0:   begin tap = 2'd0; state_d = ST_R1; end
            ST_R1:   begin tap = 2'd1; max_d = rd_val; state_d = ST_R2; end
            ST_R2:   begin tap = 2'd2; max_d = smax(max_q, rd_val); state_d = ST_R3; end
            ST_R3:   begin tap = 2'd3; max_d = smax(max_q, rd_val); state_d = ST_LAST; end
            ST_LAST: begin max_d = smax(max_q, rd_val); state_d = ST_WR; end
            ST_WR:   state_d = last_out ? ST_FIN : ST_R0;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
        end
    end

`ifdef MAXPOOL_RELU_EN
    assign wr_val = max_q[DATA_W-1] ? '0 : max_q;
`else
    assign wr_val = max_q;
`endif

    always_comb begin
        feature_addr = '0;
        case (state_q)
            ST_R0, ST_R1, ST_R2, ST_R3: feature_addr = src_addr;
            ST_WR:                      feature_addr = dst_addr;
            default:                    feature_addr = '0;
        endcase
    end

    assign feature_data   = (state_q == ST_WR) ? wr_val : '0;
    assign feature_mem_en = (state_q == ST_WR);
    assign busy           = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign done           = (state_q == ST_FIN);

endmodule

// File: tb/tb_maxpool_unit.sv
// Bench for maxpool_unit: four instances of different geometry, each with its own
// feature memory, checked against a loop-based pooling model.
`timescale 1ns/1ps
module tb_maxpool_unit;

    localparam int NI = 4;

    // instance 0: 4x4x1 -> 100, 1: 2x2x1 -> 50, 2: 5x5x1 -> 200, 3: default 12x12x6 -> 1000
    int img_w    [NI] = '{4, 2, 5, 12};
    int img_h    [NI] = '{4, 2, 5, 12};
    int chans    [NI] = '{1, 1, 1, 6};
    int dst_base [NI] = '{100, 50, 200, 1000};

    logic        clk = 1'b0;
    logic        rst   [NI];
    logic        st    [NI];
    logic [31:0] idata [NI];
    logic [11:0] addr  [NI];
    logic [31:0] wdata [NI];
    logic        en    [NI];
    logic        busy  [NI];
    logic        done  [NI];

    logic [31:0] mem [NI][4096];
    int          wr_cnt   [NI];
    int          done_cnt [NI];
    int          bad_wr   [NI];
    int          bad_rd;

    int n_checks;
    int n_errors;

    always #5 clk = ~clk;

    maxpool_unit #(.IMG_W(4), .IMG_H(4), .CHANNELS(1), .SRC_BASE(0), .DST_BASE(100), .ADDR_W(12)) u_dut0 (
        .clk(clk), .reset(rst[0]), .start(st[0]), .feature_idata(idata[0]), .feature_addr(addr[0]),
        .feature_data(wdata[0]), .feature_mem_en(en[0]), .busy(busy[0]), .done(done[0]));
    maxpool_unit #(.IMG_W(2), .IMG_H(2), .CHANNELS(1), .SRC_BASE(0), .DST_BASE(50), .ADDR_W(12)) u_dut1 (
        .clk(clk), .reset(rst[1]), .start(st[1]), .feature_idata(idata[1]), .feature_addr(addr[1]),
        .feature_data(wdata[1]), .feature_mem_en(en[1]), .busy(busy[1]), .done(done[1]));
    maxpool_unit #(.IMG_W(5), .IMG_H(5), .CHANNELS(1), .SRC_BASE(0), .DST_BASE(200), .ADDR_W(12)) u_dut2 (
        .clk(clk), .reset(rst[2]), .start(st[2]), .feature_idata(idata[2]), .feature_addr(addr[2]),
        .feature_data(wdata[2]), .feature_mem_en(en[2]), .busy(busy[2]), .done(done[2]));
    maxpool_unit u_dut3 (
        .clk(clk), .reset(rst[3]), .start(st[3]), .feature_idata(idata[3]), .feature_addr(addr[3]),
        .feature_data(wdata[3]), .feature_mem_en(en[3]), .busy(busy[3]), .done(done[3]));

    function automatic int n_out(input int k);
        return (img_w[k] / 2) * (img_h[k] / 2) * chans[k];
    endfunction

    // Feature memories with one-cycle read latency, plus write/done/read monitors
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            idata[k] <= mem[k][addr[k]];
            if (en[k]) begin
                mem[k][addr[k]] <= wdata[k];
                wr_cnt[k] <= wr_cnt[k] + 1;
                if (int'(addr[k]) < dst_base[k] || int'(addr[k]) >= dst_base[k] + n_out(k))
                    bad_wr[k] <= bad_wr[k] + 1;
            end
            if (done[k]) done_cnt[k] <= done_cnt[k] + 1;
        end
        if (busy[2] && !en[2] && (int'(addr[2]) % 5 == 4 || int'(addr[2]) / 5 == 4))
            bad_rd <= bad_rd + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: max over the 2x2 window read straight from the source plane
    function automatic logic [31:0] exp_pool(input int k, input int c, input int oy, input int ox);
        int m;
        int v;
        m = 0;
        for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
                v = int'(mem[k][c * img_h[k] * img_w[k] + (2 * oy + dy) * img_w[k] + 2 * ox + dx]);
                if ((dy == 0 && dx == 0) || v > m) m = v;
            end
        end
`ifdef MAXPOOL_RELU_EN
        if (m < 0) m = 0;
`endif
        return 32'(m);
    endfunction

    task automatic check_map(input int k);
        int ow;
        int oh;
        ow = img_w[k] / 2;
        oh = img_h[k] / 2;
        for (int c = 0; c < chans[k]; c++)
            for (int oy = 0; oy < oh; oy++)
                for (int ox = 0; ox < ow; ox++)
                    check_eq($sformatf("k%0d_c%0d_y%0d_x%0d", k, c, oy, ox),
                             mem[k][dst_base[k] + c * oh * ow + oy * ow + ox], exp_pool(k, c, oy, ox));
    endtask

    task automatic fill_random(input int k);
        for (int i = 0; i < img_w[k] * img_h[k] * chans[k]; i++) mem[k][i] = $urandom;
    endtask

    // One pass; cycles counts edges from the one that samples start to the one that raises done
    task automatic run_pass(input int k, input int extra_at, output int cycles, output int dones, output int writes);
        int d0;
        int w0;
        d0 = done_cnt[k];
        w0 = wr_cnt[k];
        @(negedge clk);
        st[k] = 1'b1;
        @(negedge clk);
        st[k] = 1'b0;
        cycles = 1;
        while (!done[k] && cycles < 4000) begin
            st[k] = (cycles == extra_at);
            @(negedge clk);
            cycles++;
        end
        st[k] = 1'b0;
        if (!done[k]) check_eq($sformatf("k%0d_done_timeout", k), 32'(cycles), 32'(6 * n_out(k) + 1));
        repeat (3) @(negedge clk);
        dones  = done_cnt[k] - d0;
        writes = wr_cnt[k] - w0;
        $display("pass k=%0d: %0d cycles, %0d writes, %0d done pulses", k, cycles, writes, dones);
    endtask

    initial begin
        int cyc;
        int dn;
        int wr;
        int w0;
        int d0;
        logic [31:0] win [4];
        n_checks = 0;
        n_errors = 0;
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1;
            st[k]  = 1'b0;
        end
        repeat (3) @(negedge clk);

        check_eq("rst_addr", 32'(addr[0]), 32'h0);
        check_eq("rst_data", wdata[0], 32'h0);
        check_eq("rst_en", 32'(en[0]), 32'h0);
        check_eq("rst_busy", 32'(busy[0]), 32'h0);
        check_eq("rst_done", 32'(done[0]), 32'h0);
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;

        // 4x4x1 with pixels 0..15
        for (int i = 0; i < 16; i++) mem[0][i] = 32'(i);
        run_pass(0, -1, cyc, dn, wr);
        check_eq("k0_latency", 32'(cyc), 32'd25);
        check_eq("k0_m100", mem[0][100], 32'd5);
        check_eq("k0_m101", mem[0][101], 32'd7);
        check_eq("k0_m102", mem[0][102], 32'd13);
        check_eq("k0_m103", mem[0][103], 32'd15);
        check_eq("k0_writes", 32'(wr), 32'd4);
        check_eq("k0_dones", 32'(dn), 32'd1);

        // All-negative window
        win = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFE};
        for (int i = 0; i < 4; i++) mem[1][i] = win[i];
        run_pass(1, -1, cyc, dn, wr);
`ifdef MAXPOOL_RELU_EN
        check_eq("k1_neg_window", mem[1][50], 32'h00000000);
`else
        check_eq("k1_neg_window", mem[1][50], 32'hFFFFFFFF);
`endif
        check_eq("k1_latency", 32'(cyc), 32'd7);

        // Random 2x2 windows, with small signed values now and then to force ties
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 4; i++)
                mem[1][i] = (t % 3 == 0) ? 32'($urandom_range(0, 4)) - 32'd2 : $urandom;
            run_pass(1, -1, cyc, dn, wr);
            check_map(1);
        end

        // 5x5x1: trailing row and column dropped
        fill_random(2);
        run_pass(2, -1, cyc, dn, wr);
        check_map(2);
        check_eq("k2_writes", 32'(wr), 32'd4);
        check_eq("k2_bad_wr", 32'(bad_wr[2]), 32'd0);
        check_eq("k2_bad_rd", 32'(bad_rd), 32'd0);
        check_eq("k2_latency", 32'(cyc), 32'd25);

        // Default geometry with a second start pulsed mid-pass
        fill_random(3);
        run_pass(3, 100, cyc, dn, wr);
        check_map(3);
        check_eq("k3_latency", 32'(cyc), 32'd1297);
        check_eq("k3_writes", 32'(wr), 32'd216);
        check_eq("k3_dones", 32'(dn), 32'd1);
        check_eq("k3_bad_wr", 32'(bad_wr[3]), 32'd0);

        // Reset during R2 of the second output on the 4x4x1 instance
        fill_random(0);
        for (int i = 100; i < 104; i++) mem[0][i] = 32'hDEADBEEF;
        w0 = wr_cnt[0];
        d0 = done_cnt[0];
        @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("k0_mid_busy", 32'(busy[0]), 32'd1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check_eq("k0_rst_en", 32'(en[0]), 32'd0);
        check_eq("k0_rst_busy", 32'(busy[0]), 32'd0);
        repeat (30) @(negedge clk);
        check_eq("k0_rst_dones", 32'(done_cnt[0] - d0), 32'd0);
        check_eq("k0_rst_writes", 32'(wr_cnt[0] - w0), 32'd1);
        check_eq("k0_partial", mem[0][100], exp_pool(0, 0, 0, 0));
        check_eq("k0_untouched", mem[0][101], 32'hDEADBEEF);
        run_pass(0, -1, cyc, dn, wr);
        check_map(0);
        check_eq("k0_rerun_latency", 32'(cyc), 32'd25);
        check_eq("k0_rerun_dones", 32'(dn), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/maxpool_unit.md
Name: maxpool_unit

Overview:
- Layer-1 stage directly downstream of the convolution pass in processor_ctrl.
- Reads conv results (signed 32-bit, channel-major, row-major) from feature memory.
- Applies 2x2 max pooling, stride 2, per channel, and writes the pooled map back into feature memory.
- Runs once per start pulse; signals completion with a done pulse.

Parameters:
- IMG_W, 12, conv output width per channel (>=2)
- IMG_H, 12, conv output height per channel (>=2)
- CHANNELS, 6, number of channel planes
- SRC_BASE, 0, feature-memory word address of channel 0 pixel (0,0)
- DST_BASE, 1000, feature-memory word address of first pooled output
- ADDR_W, 12, feature-memory address width

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears the block on the next rising clk edge
- start  in  1  begin one pooling pass; sampled only in IDLE
- feature_idata  in  32  read data, valid the cycle after feature_addr is driven (1-cycle latency)
- feature_addr  out  ADDR_W  read or write address
- feature_data  out  32  write data
- feature_mem_en  out  1  write strobe; memory captures on the rising edge where it is 1
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final write

Behaviour:
- Reset values: feature_addr=0, feature_data=0, feature_mem_en=0, busy=0, done=0; FSM=IDLE; all counters 0.
- Reset mid-pass forces IDLE on the next edge. No further writes occur; partial results already written stay in memory.
- Output geometry:
  - OW=floor(IMG_W/2), OH=floor(IMG_H/2).
  - For odd IMG_W or IMG_H, the last column or row is dropped.
  - Iteration order: channel c outer, then oy, then ox inner.
- Read addresses: src(dy,dx) = SRC_BASE + c*IMG_H*IMG_W + (2*oy+dy)*IMG_W + 2*ox+dx.
  - Read order: (0,0),(0,1),(1,0),(1,1).
- Write address: dst = DST_BASE + c*OH*OW + oy*OW + ox.
- All address arithmetic is modulo 2^ADDR_W (wrap, no error).
- FSM, 6 cycles per output, one state per cycle:
  - IDLE: start=1 -> R0; start=0 -> stay.
  - R0: drive src(0,0).
  - R1: drive src(0,1); capture idata into max.
  - R2: drive src(1,0); max = signed max(max, idata).
  - R3: drive src(1,1); update max.
  - LAST: update max.
  - WR: feature_addr=dst, feature_data=max, feature_mem_en=1; advance ox/oy/c.
  - WR -> R0 if outputs remain, else FIN.
  - FIN: done=1 for one cycle, busy=0 -> IDLE.
- feature_mem_en is 1 only in WR.
- Compare is two's-complement signed. On ties, either operand may be kept (values are equal).
- Total latency from start accepted to done = 6*OW*OH*CHANNELS + 1 cycles.
- start while busy is ignored; no queuing.
- start held high through FIN re-triggers a new pass from IDLE on the following cycle.

Optional Feature:
- Macro MAXPOOL_RELU_EN.
- Defined: the written value is max(pooled, 0); a negative result writes 32'h0000_0000.
- Undefined: the raw signed maximum is written.
- Timing and addresses are identical either way.

Decomposition:
- Shared package cnn_pkg holds:
  - DATA_W=32, FEAT_ADDR_W=12
  - state encoding localparams (IDLE,R0,R1,R2,R3,LAST,WR,FIN)
  - a signed-max function, reused by later layers
- One natural sub-module: maxpool_addr_gen (c/oy/ox/dy/dx counters, src/dst address computation), leaving the FSM and compare datapath in the top.

Test Plan:
- 4x4x1, SRC_BASE=0, DST_BASE=100, pixels 0..15 -> mem[100..103] = 5,7,13,15; done exactly 25 cycles after start accepted.
- Window {-3,-1,-7,-2} (hex FFFFFFFD,FFFFFFFF,FFFFFFF9,FFFFFFFE) -> FFFFFFFF without MAXPOOL_RELU_EN; 00000000 with MAXPOOL_RELU_EN.
- Default 12x12x6, L0 conv data at mem[0..863] -> mem[1000..1215] matches the layer-1 golden file, 0 errors; exactly 216 write strobes counted.
- 5x5x1 -> 4 outputs only; row 4 and column 4 never addressed; no write outside DST_BASE..DST_BASE+3.
- reset=1 asserted during R2 of the 2nd output -> next edge feature_mem_en=0, busy=0, done never pulses; new start completes a full, correct pass.
- start pulsed again while busy -> ignored; exactly one done pulse; write count unchanged.
